// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong scheduler for a shared simple-dual-port sample BRAM: the writer fills one
// bank while the other is streamed out as an AXI-Stream frame with tlast.
module bram_pingpong_ctrl #(
   parameter int FRAME_LEN  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = $clog2(2*FRAME_LEN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_waddr,
   output logic [DATA_WIDTH-1:0] bram_wdata,
   output logic                  bram_ren,
   output logic [ADDR_WIDTH-1:0] bram_raddr,
   input  logic [DATA_WIDTH-1:0] bram_rdata,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic [15:0]           frame_cnt
);
   localparam int OW = ADDR_WIDTH - 1;
   localparam logic [OW-1:0] LAST_OFF = OW'(FRAME_LEN - 1);

   logic [1:0]    full_q, full_d;
   logic          wb_q, wb_d, rb_q, rb_d;
   logic [OW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic          infl_q, infl_last_q;
   logic [1:0]    cnt_q, cnt_d;
   logic          wptr_q, wptr_d, rptr_q, rptr_d;
   logic [15:0]   fcnt_q, fcnt_d;
   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [1:0]            fifo_last_q;

   logic       wr_xfer, wr_last, rd_issue, rd_last, pop, head_last;
   logic [2:0] occ;

   assign wr_ready  = rst & ~full_q[wb_q];
   assign wr_xfer   = wr_valid & wr_ready;
   assign wr_last   = wr_xfer & (wp_q == LAST_OFF);
   assign m_tvalid  = rst & (cnt_q != 2'd0);
   assign pop       = m_tvalid & m_tready;
   assign head_last = fifo_last_q[rptr_q];

   // Words already buffered or in flight, net of this cycle's pop, must leave a FIFO slot.
   assign occ      = {1'b0, cnt_q} + 3'(infl_q) - 3'(pop);
   assign rd_issue = rst & full_q[rb_q] & (occ < 3'd2);
   assign rd_last  = rd_issue & (rp_q == LAST_OFF);

   assign bram_we    = wr_xfer;
   assign bram_waddr = wr_xfer ? {wb_q, wp_q} : '0;
   assign bram_wdata = wr_xfer ? wr_data : '0;
   assign bram_ren   = rd_issue;
   assign bram_raddr = rd_issue ? {rb_q, rp_q} : '0;
   assign m_tdata    = m_tvalid ? fifo_data_q[rptr_q] : '0;
   assign m_tlast    = m_tvalid & head_last;
   assign frame_cnt  = fcnt_q;

   always_comb begin
      full_d = full_q;
      wb_d   = wb_q;
      wp_d   = wp_q;
      rb_d   = rb_q;
      rp_d   = rp_q;
      if (wr_xfer) begin
         wp_d = wp_q + OW'(1);
         if (wr_last) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
         end
      end
      // Releasing at issue is safe: the writer restarts the bank at offset 0.
      if (rd_issue) begin
         rp_d = rp_q + OW'(1);
         if (rd_last) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
         end
      end
      cnt_d  = cnt_q + 2'(infl_q) - 2'(pop);
      wptr_d = wptr_q ^ infl_q;
      rptr_d = rptr_q ^ pop;
      fcnt_d = fcnt_q + 16'(pop & head_last);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         full_q      <= '0;
         wb_q        <= 1'b0;
         wp_q        <= '0;
         rb_q        <= 1'b0;
         rp_q        <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         cnt_q       <= '0;
         wptr_q      <= 1'b0;
         rptr_q      <= 1'b0;
         fcnt_q      <= '0;
      end else begin
         full_q      <= full_d;
         wb_q        <= wb_d;
         wp_q        <= wp_d;
         rb_q        <= rb_d;
         rp_q        <= rp_d;
         infl_q      <= rd_issue;
         infl_last_q <= rd_last;
         cnt_q       <= cnt_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         fcnt_q      <= fcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (infl_q) begin
         fifo_data_q[wptr_q] <= bram_rdata;
         fifo_last_q[wptr_q] <= infl_last_q;
      end
   end
endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// Self-checking bench for bram_pingpong_ctrl with a behavioural 1-cycle-latency BRAM.
module tb_bram_pingpong_ctrl;
   localparam int FL = 32;
   localparam int DW = 32;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic          bram_we;
   logic [AW-1:0] bram_waddr;
   logic [DW-1:0] bram_wdata;
   logic          bram_ren;
   logic [AW-1:0] bram_raddr;
   logic [DW-1:0] bram_rdata;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic          m_tlast;
   logic [15:0]   frame_cnt;

   bram_pingpong_ctrl #(.FRAME_LEN(FL), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
      .bram_ren(bram_ren), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .frame_cnt(frame_cnt));

   always #5 clk = ~clk;

   logic [DW-1:0] mem [2*FL];
   always_ff @(posedge clk) begin
      if (bram_we) mem[bram_waddr] <= bram_wdata;
      if (bram_ren) bram_rdata <= mem[bram_raddr];
   end

   typedef struct {
      logic          wv;
      logic [DW-1:0] wd;
      logic          tr;
      logic          e_wr_ready;
      logic          e_we;
      logic [AW-1:0] e_waddr;
      logic [DW-1:0] e_wdata;
      logic          e_ren;
      logic [AW-1:0] e_raddr;
      logic          e_tvalid;
      logic [DW-1:0] e_tdata;
      logic          e_tlast;
      logic [15:0]   e_fcnt;
   } vec_t;
   vec_t vecs [70];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic          xfer;
   logic [AW-1:0] last_waddr;
   logic          stall_v = 1'b0;
   logic [DW-1:0] stall_d;
   logic          stall_l;
   logic [DW-1:0] got_d [$];
   bit            got_l [$];
   int            pop_cyc [$];
   int            raddr_q [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock: observe at the falling edge, return just after the rising edge.
   task automatic tick();
      @(negedge clk);
      xfer = wr_valid & wr_ready;
      if (xfer) last_waddr = bram_waddr;
      if (bram_ren) raddr_q.push_back(int'(bram_raddr));
      if (rst) begin
         if (stall_v) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data", m_tdata, stall_d);
            chk("hold_last", m_tlast, stall_l);
         end
         if (m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_l.push_back(m_tlast);
            pop_cyc.push_back(cyc);
         end
      end
      stall_v = rst && m_tvalid && !m_tready;
      stall_d = m_tdata;
      stall_l = m_tlast;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic reset_dut();
      rst = 1'b0; wr_valid = 1'b0; m_tready = 1'b0; wr_data = '0;
      tick(); tick();
      rst = 1'b1;
      stall_v = 1'b0;
      got_d.delete(); got_l.delete(); pop_cyc.delete(); raddr_q.delete();
   endtask

   task automatic check_stream(input string nm, input int n, input int base);
      chk({nm, "_count"}, got_d.size(), n);
      for (int i = 0; i < n && i < got_d.size(); i++) begin
         chk({nm, "_data"}, got_d[i], base + i);
         chk({nm, "_last"}, got_l[i], (i % FL) == FL - 1);
      end
   endtask

   initial begin
      int wi, n, stuck;

      // Single frame at full rate: every cycle's outputs from a precomputed table.
      for (int c = 0; c < 70; c++) begin
         vecs[c].wv         = c < FL;
         vecs[c].wd         = (c < FL) ? 32'hA000 + c : '0;
         vecs[c].tr         = 1'b1;
         vecs[c].e_wr_ready = 1'b1;
         vecs[c].e_we       = c < FL;
         vecs[c].e_waddr    = (c < FL) ? AW'(c) : '0;
         vecs[c].e_wdata    = vecs[c].wd;
         vecs[c].e_ren      = c >= 32 && c <= 63;
         vecs[c].e_raddr    = vecs[c].e_ren ? AW'(c - 32) : '0;
         vecs[c].e_tvalid   = c >= 34 && c <= 65;
         vecs[c].e_tdata    = vecs[c].e_tvalid ? 32'hA000 + (c - 34) : '0;
         vecs[c].e_tlast    = c == 65;
         vecs[c].e_fcnt     = (c >= 66) ? 16'd1 : 16'd0;
      end

      reset_dut();
      for (int c = 0; c < 70; c++) begin
         wr_valid = vecs[c].wv; wr_data = vecs[c].wd; m_tready = vecs[c].tr;
         #1;
         chk("t1_wr_ready", wr_ready, vecs[c].e_wr_ready);
         chk("t1_we", bram_we, vecs[c].e_we);
         chk("t1_waddr", bram_waddr, vecs[c].e_waddr);
         chk("t1_wdata", bram_wdata, vecs[c].e_wdata);
         chk("t1_ren", bram_ren, vecs[c].e_ren);
         chk("t1_raddr", bram_raddr, vecs[c].e_raddr);
         chk("t1_tvalid", m_tvalid, vecs[c].e_tvalid);
         chk("t1_tdata", m_tdata, vecs[c].e_tdata);
         chk("t1_tlast", m_tlast, vecs[c].e_tlast);
         chk("t1_fcnt", frame_cnt, vecs[c].e_fcnt);
         tick();
      end

      // Backpressure: both banks fill, writer stalls, then everything drains in order.
      reset_dut();
      wi = 0; n = 0;
      while (wi < 2*FL && n < 500) begin
         wr_valid = 1'b1; wr_data = wi; tick();
         if (xfer) wi++;
         n++;
      end
      wr_data = wi; #1;
      chk("bp_wr_ready_low", wr_ready, 0);
      stuck = 0;
      repeat (5) begin tick(); if (xfer) stuck++; end
      chk("bp_no_xfer", stuck, 0);
      chk("bp_no_out", got_d.size(), 0);
      chk("bp_tvalid", m_tvalid, 1);
      m_tready = 1'b1; n = 0;
      while ((wi < 3*FL || got_d.size() < 3*FL) && n < 1000) begin
         wr_valid = wi < 3*FL; wr_data = wi; tick();
         if (xfer) begin
            if (wi == 2*FL) chk("bp_w64_bank0", last_waddr, 0);
            wi++;
         end
         n++;
      end
      check_stream("bp", 3*FL, 0);
      chk("bp_fcnt", frame_cnt, 3);

      // Random valid/ready over 10 frames.
      reset_dut();
      wi = 0; n = 0;
      while (got_d.size() < 10*FL && n < 6000) begin
         wr_valid = (wi < 10*FL) && ($urandom_range(0, 1) == 1);
         wr_data = wi;
         m_tready = $urandom_range(0, 1) == 1;
         tick();
         if (xfer) wi++;
         n++;
      end
      check_stream("rnd", 10*FL, 0);
      chk("rnd_fcnt", frame_cnt, 10);

      // Two full banks drain back-to-back with no bubble at the swap.
      reset_dut();
      wi = 0; n = 0;
      while (wi < 2*FL && n < 500) begin
         wr_valid = 1'b1; wr_data = 1000 + wi; tick();
         if (xfer) wi++;
         n++;
      end
      wr_valid = 1'b0; m_tready = 1'b1; n = 0;
      while (got_d.size() < 2*FL && n < 300) begin tick(); n++; end
      check_stream("b2b", 2*FL, 1000);
      if (pop_cyc.size() == 2*FL) chk("b2b_gapless", pop_cyc[2*FL-1] - pop_cyc[0], 2*FL - 1);
      chk("b2b_raddr_count", raddr_q.size(), 2*FL);
      for (int i = 0; i < raddr_q.size() && i < 2*FL; i++) chk("b2b_raddr", raddr_q[i], i);

      // Reset mid-stream: outputs forced idle, then a clean frame from bank 0.
      reset_dut();
      wi = 0; n = 0;
      while (wi < FL + 17 && n < 500) begin
         wr_valid = 1'b1; wr_data = wi; tick();
         if (xfer) wi++;
         n++;
      end
      wr_valid = 1'b0; m_tready = 1'b1; n = 0;
      while (got_d.size() < 5 && n < 100) begin tick(); n++; end
      chk("mr_pre_pops", got_d.size(), 5);
      rst = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEAD; m_tready = 1'b1; #1;
      chk("mr_wr_ready", wr_ready, 0);
      chk("mr_we", bram_we, 0);
      chk("mr_waddr", bram_waddr, 0);
      chk("mr_wdata", bram_wdata, 0);
      chk("mr_ren", bram_ren, 0);
      chk("mr_raddr", bram_raddr, 0);
      chk("mr_tvalid", m_tvalid, 0);
      chk("mr_tlast", m_tlast, 0);
      chk("mr_tdata", m_tdata, 0);
      tick();
      rst = 1'b1; wr_valid = 1'b0; #1;
      chk("mr_post_tvalid", m_tvalid, 0);
      chk("mr_post_wr_ready", wr_ready, 1);
      chk("mr_post_fcnt", frame_cnt, 0);
      got_d.delete(); got_l.delete(); pop_cyc.delete();
      wi = 0; n = 0;
      while ((wi < FL || got_d.size() < FL) && n < 300) begin
         wr_valid = wi < FL; wr_data = wi; tick();
         if (xfer) begin
            if (wi == 0) chk("mr_first_waddr", last_waddr, 0);
            wi++;
         end
         n++;
      end
      wr_valid = 1'b0;
      repeat (6) tick();
      check_stream("mr", FL, 0);
      chk("mr_fcnt", frame_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
